// File: rtl/stream_merge_sink_if.sv
// Handshake bundle between two result pipelines, the merge sink and its consumer.
// Ports: in_data_N/in_valid_N from pipeline N, out_ready from downstream;
//        out_data/out_src/out_valid to downstream, stall/overflow_err to both pipelines.
interface stream_merge_sink_if;
   logic [31:0] in_data_1;
   logic        in_valid_1;
   logic [31:0] in_data_2;
   logic        in_valid_2;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_src;
   logic        out_valid;
   logic        stall;
   logic        overflow_err;

   // Sink side: the merge block itself.
   modport slave (
      input  in_data_1, in_valid_1, in_data_2, in_valid_2, out_ready,
      output out_data, out_src, out_valid, stall, overflow_err
   );

   // Driver side: pipelines plus downstream consumer (or a testbench).
   modport master (
      output in_data_1, in_valid_1, in_data_2, in_valid_2, out_ready,
      input  out_data, out_src, out_valid, stall, overflow_err
   );
endinterface

// File: rtl/stream_merge_sink.sv
// Merges two 32-bit result streams through per-source FIFOs into one registered output.
// Ports: clk, reset (sync, active-high), bus (stream_merge_sink_if.slave).
// Latency: word written at edge t reaches out_data after edge t+1; stall asserted from next-state counts.
module stream_merge_sink #(
   parameter int DEPTH      = 4,
   parameter int HIGH_WATER = DEPTH - 1
) (
   input  logic                clk,
   input  logic                reset,
   stream_merge_sink_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] HW_CNT   = CW'(HIGH_WATER);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [31:0]   mem_1 [DEPTH];
   logic [31:0]   mem_2 [DEPTH];
   logic [AW-1:0] wr_ptr_1, rd_ptr_1, wr_ptr_2, rd_ptr_2;
   logic [CW-1:0] count_1, count_2, next_count_1, next_count_2;
   logic          last_grant;   // 0 = source 1 granted last, 1 = source 2

   logic ne_1, ne_2, full_1, full_2, load;
   logic pop_1, pop_2, push_1, push_2, drop;

   always_comb begin
      ne_1   = (count_1 != '0);
      ne_2   = (count_2 != '0);
      full_1 = (count_1 == FULL_CNT);
      full_2 = (count_2 == FULL_CNT);
      load   = !bus.out_valid || bus.out_ready;
      // Round-robin: under contention grant the source not served last.
      pop_1  = load && ne_1 && (!ne_2 ||  last_grant);
      pop_2  = load && ne_2 && (!ne_1 || !last_grant);
      // A full FIFO still accepts when the same edge pops it.
      push_1 = bus.in_valid_1 && (!full_1 || pop_1);
      push_2 = bus.in_valid_2 && (!full_2 || pop_2);
      drop   = (bus.in_valid_1 && !push_1) || (bus.in_valid_2 && !push_2);
      next_count_1 = count_1 + {{AW{1'b0}}, push_1} - {{AW{1'b0}}, pop_1};
      next_count_2 = count_2 + {{AW{1'b0}}, push_2} - {{AW{1'b0}}, pop_2};
   end

   // Storage is not reset; counts and pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (push_1) mem_1[wr_ptr_1] <= bus.in_data_1;
         if (push_2) mem_2[wr_ptr_2] <= bus.in_data_2;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_1         <= '0;
         rd_ptr_1         <= '0;
         wr_ptr_2         <= '0;
         rd_ptr_2         <= '0;
         count_1          <= '0;
         count_2          <= '0;
         last_grant       <= 1'b1;
         bus.out_valid    <= 1'b0;
         bus.out_data     <= '0;
         bus.out_src      <= 1'b0;
         bus.stall        <= 1'b0;
         bus.overflow_err <= 1'b0;
      end else begin
         if (push_1) wr_ptr_1 <= wr_ptr_1 + PTR_ONE;
         if (push_2) wr_ptr_2 <= wr_ptr_2 + PTR_ONE;
         if (pop_1)  rd_ptr_1 <= rd_ptr_1 + PTR_ONE;
         if (pop_2)  rd_ptr_2 <= rd_ptr_2 + PTR_ONE;
         count_1 <= next_count_1;
         count_2 <= next_count_2;

         if (load) begin
            bus.out_valid <= pop_1 || pop_2;
            if (pop_1) begin
               bus.out_data <= mem_1[rd_ptr_1];
               bus.out_src  <= 1'b0;
               last_grant   <= 1'b0;
            end else if (pop_2) begin
               bus.out_data <= mem_2[rd_ptr_2];
               bus.out_src  <= 1'b1;
               last_grant   <= 1'b1;
            end
         end

         bus.stall <= (next_count_1 >= HW_CNT) || (next_count_2 >= HW_CNT);
         if (drop) bus.overflow_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_stream_merge_sink.sv
// Directed bench for stream_merge_sink: reset, latency, arbitration, backpressure,
// overflow, full push/pop and mid-stream reset. Inputs driven and outputs sampled
// on the falling edge; DUT state changes on the rising edge.
module tb_stream_merge_sink;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] got_data [$];
   logic        got_src  [$];

   stream_merge_sink_if bus ();

   stream_merge_sink #(.DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.in_valid_1 = 1'b0;
      bus.in_valid_2 = 1'b0;
      bus.in_data_1  = '0;
      bus.in_data_2  = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      step();
      reset = 1'b0;
   endtask

   // Consumes output for a fixed number of cycles, recording every accepted word.
   task automatic drain(input int budget);
      got_data.delete();
      got_src.delete();
      bus.out_ready = 1'b1;
      for (int i = 0; i < budget; i++) begin
         if (bus.out_valid) begin
            got_data.push_back(bus.out_data);
            got_src.push_back(bus.out_src);
         end
         step();
      end
   endtask

   task automatic test_reset();
      bus.out_ready  = 1'b1;
      bus.in_valid_1 = 1'b1;
      bus.in_data_1  = 32'h99;
      step();
      step();
      // Reset with a push pending: reset must win.
      reset = 1'b1;
      bus.in_valid_1 = 1'b1;
      step();
      reset = 1'b0;
      idle_inputs();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", bus.out_data); end
      checks++; if (bus.out_src !== 1'b0) begin errors++; $display("FAIL reset_out_src got %b exp 0", bus.out_src); end
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus.stall); end
      checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", bus.overflow_err); end
      step();
      step();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_push got %b exp 0", bus.out_valid); end
   endtask

   task automatic test_single();
      do_reset();
      bus.out_ready  = 1'b1;
      bus.in_valid_1 = 1'b1;
      bus.in_data_1  = 32'h11;
      step();                       // write edge
      idle_inputs();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass got %b exp 0", bus.out_valid); end
      step();                       // pop edge
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", bus.out_valid); end
      checks++; if (bus.out_data !== 32'h11) begin errors++; $display("FAIL single_data got %h exp 11", bus.out_data); end
      checks++; if (bus.out_src !== 1'b0) begin errors++; $display("FAIL single_src got %b exp 0", bus.out_src); end
      step();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop got %b exp 0", bus.out_valid); end
   endtask

   task automatic test_contention();
      logic [31:0] exp_d [8];
      logic        exp_s [8];
      int n;
      int gaps;
      exp_d = '{32'h100, 32'h200, 32'h101, 32'h201, 32'h102, 32'h202, 32'h103, 32'h203};
      exp_s = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      n = 0;
      gaps = 0;
      do_reset();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         if (i < 4) begin
            bus.in_valid_1 = 1'b1; bus.in_data_1 = 32'h100 + 32'(i);
            bus.in_valid_2 = 1'b1; bus.in_data_2 = 32'h200 + 32'(i);
         end else begin
            idle_inputs();
         end
         if (bus.out_valid) begin
            if (n < 8) begin
               checks++; if (bus.out_data !== exp_d[n] || bus.out_src !== exp_s[n]) begin
                  errors++; $display("FAIL contention_word%0d got %h/%b exp %h/%b", n, bus.out_data, bus.out_src, exp_d[n], exp_s[n]);
               end
            end
            n++;
         end else if (n > 0 && n < 8) begin
            gaps++;
         end
         step();
      end
      checks++; if (n !== 8) begin errors++; $display("FAIL contention_count got %0d exp 8", n); end
      checks++; if (gaps !== 0) begin errors++; $display("FAIL contention_gaps got %0d exp 0", gaps); end
      checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("FAIL contention_overflow got %b exp 0", bus.overflow_err); end
   endtask

   task automatic test_backpressure();
      logic [31:0] v;
      int pushed;
      v = 32'hA0;
      pushed = 0;
      do_reset();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (!bus.stall) begin
            bus.in_valid_1 = 1'b1; bus.in_data_1 = v;
            v++; pushed++;
         end else begin
            idle_inputs();
         end
         step();
      end
      idle_inputs();
      // One word sits in the output register, three fill the FIFO to HIGH_WATER.
      checks++; if (pushed !== 4) begin errors++; $display("FAIL bp_pushed got %0d exp 4", pushed); end
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL bp_stall got %b exp 1", bus.stall); end
      checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("FAIL bp_overflow got %b exp 0", bus.overflow_err); end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA0) begin
         errors++; $display("FAIL bp_hold got %b/%h exp 1/a0", bus.out_valid, bus.out_data);
      end
      drain(8);
      checks++; if (got_data.size() !== 4) begin errors++; $display("FAIL bp_drain_count got %0d exp 4", got_data.size()); end
      for (int k = 0; k < 4 && k < got_data.size(); k++) begin
         checks++; if (got_data[k] !== 32'hA0 + 32'(k)) begin errors++; $display("FAIL bp_order%0d got %h exp %h", k, got_data[k], 32'hA0 + 32'(k)); end
      end
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL bp_stall_release got %b exp 0", bus.stall); end
   endtask

   task automatic test_overflow();
      do_reset();
      bus.out_ready = 1'b0;
      // Occupy the output register so FIFO 2 alone absorbs the burst.
      bus.in_valid_1 = 1'b1; bus.in_data_1 = 32'h77;
      step();
      idle_inputs();
      step();
      for (int i = 0; i < 5; i++) begin
         bus.in_valid_2 = 1'b1; bus.in_data_2 = 32'hB0 + 32'(i);
         step();
         if (i == 3) begin
            checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", bus.overflow_err); end
         end
      end
      idle_inputs();
      checks++; if (bus.overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", bus.overflow_err); end
      drain(10);
      checks++; if (got_data.size() !== 5) begin errors++; $display("FAIL ovf_drain_count got %0d exp 5", got_data.size()); end
      if (got_data.size() > 0) begin
         checks++; if (got_data[0] !== 32'h77 || got_src[0] !== 1'b0) begin errors++; $display("FAIL ovf_first got %h/%b exp 77/0", got_data[0], got_src[0]); end
      end
      for (int k = 1; k < 5 && k < got_data.size(); k++) begin
         checks++; if (got_data[k] !== 32'hB0 + 32'(k - 1) || got_src[k] !== 1'b1) begin
            errors++; $display("FAIL ovf_word%0d got %h/%b exp %h/1", k, got_data[k], got_src[k], 32'hB0 + 32'(k - 1));
         end
      end
      checks++; if (bus.overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", bus.overflow_err); end
      do_reset();
      checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", bus.overflow_err); end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.in_valid_1 = 1'b1; bus.in_data_1 = 32'hD0 + 32'(i);
         step();
      end
      // Output holds D0, FIFO 1 holds D1..D4 (full).
      checks++; if (bus.out_data !== 32'hD0 || bus.overflow_err !== 1'b0) begin
         errors++; $display("FAIL fpp_setup got %h/%b exp d0/0", bus.out_data, bus.overflow_err);
      end
      bus.out_ready = 1'b1;
      bus.in_valid_1 = 1'b1; bus.in_data_1 = 32'hF0;
      step();
      idle_inputs();
      checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("FAIL fpp_overflow got %b exp 0", bus.overflow_err); end
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL fpp_stall got %b exp 1", bus.stall); end
      drain(10);
      checks++; if (got_data.size() !== 5) begin errors++; $display("FAIL fpp_drain_count got %0d exp 5", got_data.size()); end
      for (int k = 0; k < 4 && k < got_data.size(); k++) begin
         checks++; if (got_data[k] !== 32'hD1 + 32'(k)) begin errors++; $display("FAIL fpp_word%0d got %h exp %h", k, got_data[k], 32'hD1 + 32'(k)); end
      end
      if (got_data.size() > 0) begin
         checks++; if (got_data[got_data.size() - 1] !== 32'hF0) begin errors++; $display("FAIL fpp_last got %h exp f0", got_data[got_data.size() - 1]); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.in_valid_1 = 1'b1; bus.in_data_1 = 32'hC0 + 32'(i);
         step();
      end
      idle_inputs();
      checks++; if (bus.out_valid !== 1'b1 || bus.stall !== 1'b1) begin
         errors++; $display("FAIL mid_setup got %b/%b exp 1/1", bus.out_valid, bus.stall);
      end
      do_reset();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mid_stall got %b exp 0", bus.stall); end
      bus.out_ready  = 1'b1;
      bus.in_valid_1 = 1'b1; bus.in_data_1 = 32'h55;
      step();
      idle_inputs();
      drain(6);
      checks++; if (got_data.size() !== 1) begin errors++; $display("FAIL mid_drain_count got %0d exp 1", got_data.size()); end
      if (got_data.size() > 0) begin
         checks++; if (got_data[0] !== 32'h55 || got_src[0] !== 1'b0) begin errors++; $display("FAIL mid_first got %h/%b exp 55/0", got_data[0], got_src[0]); end
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.out_ready = 1'b0;
      idle_inputs();
      @(negedge clk);
      step();
      reset = 1'b0;
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_overflow();
      test_full_push_pop();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
